// File: rtl/decode_queue.sv
// Decode stage for the RV32I core: a DEPTH-entry circular instruction queue
// whose head is fully decoded into a registered valid/ready issue port.
module decode_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              in_valid,
    input  logic [31:0]       in_inst,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic              in_pre_j,
    output logic              in_ready,
    input  logic              issue_ready,
    output logic              issue_valid,
    output logic [6:0]        issue_opcode,
    output logic [2:0]        issue_funct3,
    output logic              issue_funct7,
    output logic [4:0]        issue_rd,
    output logic [4:0]        issue_rs1,
    output logic [4:0]        issue_rs2,
    output logic [31:0]       issue_imm,
    output logic [ADDR_W-1:0] issue_pc,
    output logic              issue_pre_j,
    output logic              issue_illegal,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0]       inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DEPTH-1:0]  pj_mem;
    logic [PTR_W-1:0]  head, tail;

    // Valid/ready: a beat moves on a rising edge only when valid && ready && rdy && !rollback;
    // the sender holds its payload stable while valid && !ready.
    logic push, load, consume, slot_free;
    assign in_ready  = rst && rdy && !rollback && (count < CNT_W'(DEPTH));
    assign push      = in_valid && in_ready;
    assign slot_free = !issue_valid || issue_ready;
    assign load      = rdy && !rollback && (count != '0) && slot_free;
    assign consume   = rdy && !rollback && issue_valid && issue_ready;

    logic [31:0] h_inst;
    logic [31:0] d_imm;
    logic        d_legal, d_rd_en, d_rs1_en, d_rs2_en, d_f7;
    assign h_inst = inst_mem[head];

    always_comb begin
        d_imm    = '0;
        d_legal  = 1'b1;
        d_rd_en  = 1'b1;
        d_rs1_en = 1'b1;
        d_rs2_en = 1'b0;
        d_f7     = 1'b0;
        case (h_inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                d_imm    = {h_inst[31:12], 12'b0};
                d_rs1_en = 1'b0;
            end
            OPC_JAL: begin
                d_imm    = {{11{h_inst[31]}}, h_inst[31], h_inst[19:12], h_inst[20],
                            h_inst[30:21], 1'b0};
                d_rs1_en = 1'b0;
            end
            OPC_JALR, OPC_LOAD: d_imm = {{20{h_inst[31]}}, h_inst[31:20]};
            OPC_OPIMM: begin
                d_imm = {{20{h_inst[31]}}, h_inst[31:20]};
                // Only the shifts carry a funct7 bit (SRAI vs SRLI); SLLI included for symmetry.
                d_f7  = (h_inst[14:12] == 3'b001 || h_inst[14:12] == 3'b101) ? h_inst[30] : 1'b0;
            end
            OPC_STORE: begin
                d_imm    = {{20{h_inst[31]}}, h_inst[31:25], h_inst[11:7]};
                d_rd_en  = 1'b0;
                d_rs2_en = 1'b1;
            end
            OPC_BRANCH: begin
                d_imm    = {{19{h_inst[31]}}, h_inst[31], h_inst[7], h_inst[30:25],
                            h_inst[11:8], 1'b0};
                d_rd_en  = 1'b0;
                d_rs2_en = 1'b1;
            end
            OPC_OP: begin
                d_rs2_en = 1'b1;
                d_f7     = h_inst[30];
            end
            default: d_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail] <= in_inst;
            pc_mem[tail]   <= in_pc;
            pj_mem[tail]   <= in_pre_j;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (rollback) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (load) head <= head + PTR_W'(1);
                case ({push, load})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_valid   <= 1'b0;
            issue_opcode  <= '0;
            issue_funct3  <= '0;
            issue_funct7  <= 1'b0;
            issue_rd      <= '0;
            issue_rs1     <= '0;
            issue_rs2     <= '0;
            issue_imm     <= '0;
            issue_pc      <= '0;
            issue_pre_j   <= 1'b0;
            issue_illegal <= 1'b0;
        end else if (rdy) begin
            if (rollback) begin
                issue_valid <= 1'b0;
            end else if (load) begin
                issue_valid   <= 1'b1;
                issue_opcode  <= h_inst[6:0];
                issue_funct3  <= h_inst[14:12];
                issue_funct7  <= d_f7;
                issue_rd      <= d_rd_en  ? h_inst[11:7]  : 5'd0;
                issue_rs1     <= d_rs1_en ? h_inst[19:15] : 5'd0;
                issue_rs2     <= d_rs2_en ? h_inst[24:20] : 5'd0;
                issue_imm     <= d_imm;
                issue_pc      <= pc_mem[head];
                issue_pre_j   <= pj_mem[head];
                issue_illegal <= !d_legal;
            end else if (consume) begin
                issue_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=4): decode formats, flow control,
// rollback, stall, illegal opcode and asynchronous reset.
module tb_decode_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rdy = 1'b1;
    logic              rollback = 1'b0;
    logic              in_valid = 1'b0;
    logic [31:0]       in_inst = '0;
    logic [ADDR_W-1:0] in_pc = '0;
    logic              in_pre_j = 1'b0;
    logic              in_ready;
    logic              issue_ready = 1'b0;
    logic              issue_valid;
    logic [6:0]        issue_opcode;
    logic [2:0]        issue_funct3;
    logic              issue_funct7;
    logic [4:0]        issue_rd, issue_rs1, issue_rs2;
    logic [31:0]       issue_imm;
    logic [ADDR_W-1:0] issue_pc;
    logic              issue_pre_j;
    logic              issue_illegal;
    logic [CNT_W-1:0]  count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    decode_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_pre_j(in_pre_j),
        .in_ready(in_ready), .issue_ready(issue_ready), .issue_valid(issue_valid),
        .issue_opcode(issue_opcode), .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_pre_j(issue_pre_j),
        .issue_illegal(issue_illegal), .count(count)
    );

    always #5 clk = ~clk;

    // addi x1,x0,id : immediate equals id
    function automatic logic [31:0] addi_id(input int id);
        return {12'(id), 5'd0, 3'b000, 5'd1, 7'h13};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", issue_valid); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++; if (issue_imm !== 32'h0) begin n_fail++; $display("FAIL reset_imm: got %h want 0", issue_imm); end
        @(negedge clk);
        rst = 1'b1;
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_addi();
        issue_ready = 1'b1;
        in_pre_j = 1'b1;
        drive_push(32'hFFF00093, 32'h100);
        step();
        in_valid = 1'b0;
        in_pre_j = 1'b0;
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL addi_no_bypass: got %b want 0", issue_valid); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL addi_count1: got %0d want 1", count); end
        step();
        n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", issue_valid); end
        n_checks++; if (issue_opcode !== 7'h13) begin n_fail++; $display("FAIL addi_opcode: got %h want 13", issue_opcode); end
        n_checks++; if (issue_rd !== 5'd1) begin n_fail++; $display("FAIL addi_rd: got %0d want 1", issue_rd); end
        n_checks++; if (issue_rs1 !== 5'd0) begin n_fail++; $display("FAIL addi_rs1: got %0d want 0", issue_rs1); end
        n_checks++; if (issue_rs2 !== 5'd0) begin n_fail++; $display("FAIL addi_rs2: got %0d want 0", issue_rs2); end
        n_checks++; if (issue_imm !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi_imm: got %h want ffffffff", issue_imm); end
        n_checks++; if (issue_funct7 !== 1'b0) begin n_fail++; $display("FAIL addi_funct7: got %b want 0", issue_funct7); end
        n_checks++; if (issue_illegal !== 1'b0) begin n_fail++; $display("FAIL addi_illegal: got %b want 0", issue_illegal); end
        n_checks++; if (issue_pc !== 32'h100) begin n_fail++; $display("FAIL addi_pc: got %h want 100", issue_pc); end
        n_checks++; if (issue_pre_j !== 1'b1) begin n_fail++; $display("FAIL addi_pre_j: got %b want 1", issue_pre_j); end
        step();
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b want 0", issue_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] insts [4] = '{32'h4030D113, 32'h0020A423, 32'hFE000EE3, 32'h001000EF};
        logic [6:0]  e_op  [4] = '{7'h13, 7'h23, 7'h63, 7'h6F};
        logic        e_f7  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [4:0]  e_rd  [4] = '{5'd2, 5'd0, 5'd0, 5'd1};
        logic [4:0]  e_rs1 [4] = '{5'd1, 5'd1, 5'd0, 5'd0};
        logic [4:0]  e_rs2 [4] = '{5'd0, 5'd2, 5'd0, 5'd0};
        logic [31:0] e_imm [4] = '{32'h00000403, 32'h00000008, 32'hFFFFFFFC, 32'h00000800};
        issue_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive_push(insts[i], 32'h200 + 32'(4 * i));
            else in_valid = 1'b0;
            step();
            if (i > 0) begin
                n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i - 1, issue_valid); end
                n_checks++; if (issue_opcode !== e_op[i-1]) begin n_fail++; $display("FAIL b2b_opcode[%0d]: got %h want %h", i - 1, issue_opcode, e_op[i-1]); end
                n_checks++; if (issue_funct7 !== e_f7[i-1]) begin n_fail++; $display("FAIL b2b_funct7[%0d]: got %b want %b", i - 1, issue_funct7, e_f7[i-1]); end
                n_checks++; if (issue_rd !== e_rd[i-1]) begin n_fail++; $display("FAIL b2b_rd[%0d]: got %0d want %0d", i - 1, issue_rd, e_rd[i-1]); end
                n_checks++; if (issue_rs1 !== e_rs1[i-1]) begin n_fail++; $display("FAIL b2b_rs1[%0d]: got %0d want %0d", i - 1, issue_rs1, e_rs1[i-1]); end
                n_checks++; if (issue_rs2 !== e_rs2[i-1]) begin n_fail++; $display("FAIL b2b_rs2[%0d]: got %0d want %0d", i - 1, issue_rs2, e_rs2[i-1]); end
                n_checks++; if (issue_imm !== e_imm[i-1]) begin n_fail++; $display("FAIL b2b_imm[%0d]: got %h want %h", i - 1, issue_imm, e_imm[i-1]); end
                n_checks++; if (issue_pc !== 32'h200 + 32'(4 * (i - 1))) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %h want %h", i - 1, issue_pc, 32'h200 + 32'(4 * (i - 1))); end
            end
        end
        step();
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", issue_valid); end
    endtask

    task automatic test_full();
        int next_id = 0;
        issue_ready = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 8; c++) begin
            drive_push(addi_id(next_id), 32'h300);
            if (in_ready) begin
                exp_q.push_back(32'(next_id));
                next_id++;
            end
            step();
        end
        n_checks++; if (next_id !== 5) begin n_fail++; $display("FAIL full_accepted: got %0d want 5", next_id); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        n_checks++; if (issue_imm !== 32'd0) begin n_fail++; $display("FAIL full_head_imm: got %h want 0", issue_imm); end
        issue_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_comb_path: got %b want 0", in_ready); end
        step();
        issue_ready = 1'b0;
        void'(exp_q.pop_front());
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL pulse_count: got %0d want 3", count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pulse_in_ready: got %b want 1", in_ready); end
        n_checks++; if (issue_imm !== 32'd1) begin n_fail++; $display("FAIL pulse_imm: got %h want 1", issue_imm); end
        issue_ready = 1'b1;
        for (int c = 0; c < 40 && !(next_id == 8 && exp_q.size() == 0); c++) begin
            if (issue_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL wrap_spurious: got imm %h want no issue", issue_imm);
                end else begin
                    if (issue_imm !== exp_q[0]) begin n_fail++; $display("FAIL wrap_order: got %h want %h", issue_imm, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
            end
            if (in_ready && next_id < 8) begin
                drive_push(addi_id(next_id), 32'h300);
                exp_q.push_back(32'(next_id));
                next_id++;
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        in_valid = 1'b0;
        n_checks++; if (exp_q.size() != 0 || next_id != 8) begin n_fail++; $display("FAIL wrap_drain: got %0d left want 0", exp_q.size()); end
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_final_valid: got %b want 0", issue_valid); end
    endtask

    task automatic test_rollback();
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_push(addi_id(10 + i), 32'h400);
            step();
        end
        in_valid = 1'b0;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL rb_pre_count: got %0d want 3", count); end
        n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL rb_pre_valid: got %b want 1", issue_valid); end
        rollback = 1'b1;
        issue_ready = 1'b1;
        drive_push(addi_id(20), 32'h400);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rb_in_ready: got %b want 0", in_ready); end
        step();
        rollback = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rb_count: got %0d want 0", count); end
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL rb_valid: got %b want 0", issue_valid); end
        drive_push(addi_id(21), 32'h404);
        step();
        in_valid = 1'b0;
        n_checks++; if (issue_valid !== 1'b0 || count !== 3'd1) begin n_fail++; $display("FAIL rb_push1: got valid %b count %0d want 0/1", issue_valid, count); end
        step();
        n_checks++; if (issue_valid !== 1'b1 || issue_imm !== 32'd21) begin n_fail++; $display("FAIL rb_reissue: got valid %b imm %h want 1/15", issue_valid, issue_imm); end
        step();
        n_checks++; if (issue_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL rb_drain: got valid %b count %0d want 0/0", issue_valid, count); end
    endtask

    task automatic test_stall_illegal();
        issue_ready = 1'b0;
        drive_push(addi_id(30), 32'h500);
        step();
        drive_push(addi_id(31), 32'h504);
        step();
        rdy = 1'b0;
        issue_ready = 1'b1;
        drive_push(addi_id(32), 32'h508);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++; if (count !== 3'd1 || issue_valid !== 1'b1 || issue_imm !== 32'd30) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got count %0d valid %b imm %h want 1/1/1e", c, count, issue_valid, issue_imm);
            end
        end
        rdy = 1'b1;
        in_valid = 1'b0;
        step();
        n_checks++; if (issue_imm !== 32'd31 || count !== 3'd0) begin n_fail++; $display("FAIL stall_resume: got imm %h count %0d want 1f/0", issue_imm, count); end
        step();
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b want 0", issue_valid); end
        drive_push(32'h1234567F, 32'h600);
        step();
        in_valid = 1'b0;
        step();
        n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL ill_valid: got %b want 1", issue_valid); end
        n_checks++; if (issue_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag: got %b want 1", issue_illegal); end
        n_checks++; if (issue_imm !== 32'h0) begin n_fail++; $display("FAIL ill_imm: got %h want 0", issue_imm); end
        n_checks++; if (issue_opcode !== 7'h7F) begin n_fail++; $display("FAIL ill_opcode: got %h want 7f", issue_opcode); end
        step();
    endtask

    task automatic test_async_reset();
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_push(addi_id(40 + i), 32'h700);
            step();
        end
        in_valid = 1'b0;
        n_checks++; if (issue_valid !== 1'b1 || count !== 3'd2) begin n_fail++; $display("FAIL ar_pre: got valid %b count %0d want 1/2", issue_valid, count); end
        #3 rst = 1'b0;
        #1;
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", issue_valid); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL ar_count: got %0d want 0", count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ar_in_ready: got %b want 0", in_ready); end
        n_checks++; if (issue_imm !== 32'h0 || issue_opcode !== 7'h0) begin n_fail++; $display("FAIL ar_fields: got imm %h op %h want 0/0", issue_imm, issue_opcode); end
        @(negedge clk);
        rst = 1'b1;
        issue_ready = 1'b1;
        drive_push(addi_id(50), 32'h800);
        step();
        in_valid = 1'b0;
        n_checks++; if (issue_valid !== 1'b0 || count !== 3'd1) begin n_fail++; $display("FAIL ar_refill_push: got valid %b count %0d want 0/1", issue_valid, count); end
        step();
        n_checks++; if (issue_valid !== 1'b1 || issue_imm !== 32'd50 || issue_pc !== 32'h800) begin
            n_fail++; $display("FAIL ar_refill_issue: got valid %b imm %h pc %h want 1/32/800", issue_valid, issue_imm, issue_pc);
        end
        step();
        n_checks++; if (issue_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL ar_refill_drain: got valid %b count %0d want 0/0", issue_valid, count); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_full();
        test_rollback();
        test_stall_illegal();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
